// File: rtl/regfile_param.sv
// Parameterised register file: two bypassable combinational read ports, a debug
// read port, one write port and a sequential whole-file clear engine.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              init,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              clr_req,
    output logic              wr_ready,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              wr_ready_reg;
    logic              clr_busy_reg;
    logic              clr_done_reg;
    logic [DATA_W-1:0] regs_reg [NREG];
    logic              wr_commit;

    // Writes to a hardwired-zero register are discarded here so neither the
    // array nor the bypass path ever sees them.
    assign wr_commit = we && wr_ready_reg && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (state_reg == CLEAR) begin
            regs_reg[ptr_reg] <= '0;
        end else if (wr_commit) begin
            regs_reg[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            wr_ready_reg <= 1'b1;
            clr_busy_reg <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_req) begin
                        state_reg    <= CLEAR;
                        ptr_reg      <= '0;
                        wr_ready_reg <= 1'b0;
                        clr_busy_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Pointer wraps back to 0 as the last entry is cleared.
                    ptr_reg <= ptr_reg + ADDR_W'(1);
                    if (ptr_reg == '1) begin
                        state_reg    <= DONE;
                        clr_busy_reg <= 1'b0;
                        clr_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    clr_done_reg <= 1'b0;
                    wr_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= IDLE;
                    ptr_reg      <= '0;
                    wr_ready_reg <= 1'b1;
                    clr_busy_reg <= 1'b0;
                    clr_done_reg <= 1'b0;
                end
            endcase
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic addr_zero;
            logic fwd;
            assign addr_zero   = (ZERO_REG != 0) && (rd_addr[gi] == '0);
            assign fwd         = (BYPASS != 0) && wr_commit && (waddr == rd_addr[gi]);
            assign rd_data[gi] = addr_zero ? '0 : (fwd ? wdata : regs_reg[rd_addr[gi]]);
        end
    endgenerate

    assign rdata1   = rd_data[0];
    assign rdata2   = rd_data[1];
    assign dbg_data = regs_reg[dbg_addr];
    assign wr_ready = wr_ready_reg;
    assign clr_busy = clr_busy_reg;
    assign clr_done = clr_done_reg;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default, no-bypass/no-zero and 16x8 builds
// against an array-based reference model.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        init, we, clr_req;
    logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata;
    logic [31:0] rdata1_a, rdata2_a, dbg_data_a, rdata1_b, rdata2_b, dbg_data_b;
    logic        wr_ready_a, clr_busy_a, clr_done_a, wr_ready_b, clr_busy_b, clr_done_b;

    logic        s_we, s_clr_req;
    logic [2:0]  s_waddr, s_raddr1, s_raddr2, s_dbg_addr;
    logic [15:0] s_wdata, s_rdata1, s_rdata2, s_dbg_data;
    logic        s_wr_ready, s_clr_busy, s_clr_done;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of each build plus the clear progress
    // (-1 idle, 0..31 = entry being cleared this cycle, 32 = done cycle).
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    int          clr_cyc = -1;

    always #5 clk = ~clk;

    regfile_param dut_a (
        .clk(clk), .init(init), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_a), .clr_req(clr_req),
        .wr_ready(wr_ready_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .init(init), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .clr_req(clr_req),
        .wr_ready(wr_ready_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3)) dut_s (
        .clk(clk), .init(init), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data), .clr_req(s_clr_req),
        .wr_ready(s_wr_ready), .clr_busy(s_clr_busy), .clr_done(s_clr_done)
    );

    function automatic logic [31:0] exp_a(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (we && clr_cyc < 0 && waddr == ra) return wdata;
        return ma[ra];
    endfunction

    // Advance one clock; the model applies the same edge, then wait for negedge.
    task automatic tick();
        @(posedge clk);
        if (init) begin
            for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
            clr_cyc = -1;
        end else if (clr_cyc >= 0 && clr_cyc < 32) begin
            ma[clr_cyc] = 0;
            mb[clr_cyc] = 0;
            clr_cyc++;
        end else if (clr_cyc == 32) begin
            clr_cyc = -1;
        end else begin
            if (we) begin
                if (waddr != 0) ma[waddr] = wdata;
                mb[waddr] = wdata;
            end
            if (clr_req) clr_cyc = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        init = 1; we = 1; waddr = 3; wdata = 32'hAAAA_AAAA; clr_req = 1;
        s_we = 1; s_clr_req = 1;
        tick();
        init = 0; we = 0; clr_req = 0; s_we = 0; s_clr_req = 0;
        #1;
        total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b100) begin bad++; $display("FAIL reset_flags_a got=%b want=100", {wr_ready_a, clr_busy_a, clr_done_a}); end
        total++; if ({wr_ready_b, clr_busy_b, clr_done_b} !== 3'b100) begin bad++; $display("FAIL reset_flags_b got=%b want=100", {wr_ready_b, clr_busy_b, clr_done_b}); end
        total++; if ({s_wr_ready, s_clr_busy, s_clr_done} !== 3'b100) begin bad++; $display("FAIL reset_flags_s got=%b want=100", {s_wr_ready, s_clr_busy, s_clr_done}); end
        for (int a = 0; a < 32; a++) begin
            raddr1 = a[4:0]; raddr2 = 5'(31 - a); dbg_addr = a[4:0];
            #1;
            total++; if ({rdata1_a, rdata2_a, dbg_data_a} !== 96'd0) begin bad++; $display("FAIL reset_read_a addr=%0d got=%h/%h/%h want=0", a, rdata1_a, rdata2_a, dbg_data_a); end
            total++; if ({rdata1_b, rdata2_b, dbg_data_b} !== 96'd0) begin bad++; $display("FAIL reset_read_b addr=%0d got=%h/%h/%h want=0", a, rdata1_b, rdata2_b, dbg_data_b); end
        end
    endtask

    task automatic test_write_read();
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF; raddr1 = 0; raddr2 = 0;
        tick();
        we = 0; raddr1 = 5; raddr2 = 6;
        #1;
        total++; if (rdata1_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_read_r1 got=%h want=deadbeef", rdata1_a); end
        total++; if (rdata2_a !== 32'h0) begin bad++; $display("FAIL write_read_r2 got=%h want=0", rdata2_a); end
        total++; if (rdata1_b !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_read_b got=%h want=deadbeef", rdata1_b); end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 7; wdata = 32'h1111_1111;
        tick();
        we = 1; waddr = 7; wdata = 32'h1234_5678; raddr2 = 7; raddr1 = 6;
        #1;
        total++; if (rdata2_a !== 32'h1234_5678) begin bad++; $display("FAIL bypass_on got=%h want=12345678", rdata2_a); end
        total++; if (rdata2_b !== 32'h1111_1111) begin bad++; $display("FAIL bypass_off got=%h want=11111111", rdata2_b); end
        total++; if (rdata1_a !== 32'h0) begin bad++; $display("FAIL bypass_other_port got=%h want=0", rdata1_a); end
        tick();
        we = 0;
        #1;
        total++; if (rdata2_a !== 32'h1234_5678 || rdata2_b !== 32'h1234_5678) begin bad++; $display("FAIL bypass_after got=%h/%h want=12345678", rdata2_a, rdata2_b); end
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; raddr1 = 0;
        #1;
        total++; if (rdata1_a !== 32'h0) begin bad++; $display("FAIL zero_same_cycle got=%h want=0", rdata1_a); end
        total++; if (rdata1_b !== 32'h0) begin bad++; $display("FAIL zero_b_same_cycle got=%h want=0", rdata1_b); end
        tick();
        we = 0;
        #1;
        total++; if (rdata1_a !== 32'h0) begin bad++; $display("FAIL zero_next_cycle got=%h want=0", rdata1_a); end
        total++; if (rdata1_b !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_off_reg0 got=%h want=ffffffff", rdata1_b); end
    endtask

    task automatic test_clear();
        for (int a = 1; a < 32; a++) begin
            we = 1; waddr = a[4:0]; wdata = $urandom | 32'h1;
            tick();
        end
        we = 1; waddr = 12; wdata = 32'h0000_5555; clr_req = 1;
        tick();
        we = 0; clr_req = 0;
        for (int k = 0; k < 32; k++) begin
            raddr1 = 12; raddr2 = 5'($urandom_range(0, 31));
            we = (k == 5); waddr = 3; wdata = 32'h0000_0BAD; clr_req = (k == 20);
            #1;
            total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b010) begin bad++; $display("FAIL clear_busy k=%0d got=%b want=010", k, {wr_ready_a, clr_busy_a, clr_done_a}); end
            total++; if (rdata1_a !== exp_a(raddr1)) begin bad++; $display("FAIL clear_read1 k=%0d got=%h want=%h", k, rdata1_a, exp_a(raddr1)); end
            total++; if (rdata2_a !== exp_a(raddr2)) begin bad++; $display("FAIL clear_read2 k=%0d got=%h want=%h", k, rdata2_a, exp_a(raddr2)); end
            if (k == 0) begin
                total++; if (rdata1_a !== 32'h0000_5555) begin bad++; $display("FAIL clear_same_cycle_write got=%h want=5555", rdata1_a); end
            end
            tick();
        end
        we = 1; waddr = 4; wdata = 32'h0000_0BAD; clr_req = 0;
        #1;
        total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b001) begin bad++; $display("FAIL clear_done got=%b want=001", {wr_ready_a, clr_busy_a, clr_done_a}); end
        tick();
        we = 0;
        #1;
        total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b100) begin bad++; $display("FAIL clear_idle got=%b want=100", {wr_ready_a, clr_busy_a, clr_done_a}); end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            total++; if (dbg_data_a !== 32'h0 || dbg_data_b !== 32'h0) begin bad++; $display("FAIL clear_contents addr=%0d got=%h/%h want=0", a, dbg_data_a, dbg_data_b); end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 1; a < 9; a++) begin
            we = 1; waddr = 5'(a * 3); wdata = $urandom | 32'h1;
            tick();
        end
        we = 0; clr_req = 1;
        tick();
        clr_req = 0;
        for (int k = 0; k < 10; k++) tick();
        init = 1;
        tick();
        init = 0;
        #1;
        total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== 3'b100) begin bad++; $display("FAIL abort_flags got=%b want=100", {wr_ready_a, clr_busy_a, clr_done_a}); end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            total++; if (dbg_data_a !== 32'h0) begin bad++; $display("FAIL abort_contents addr=%0d got=%h want=0", a, dbg_data_a); end
        end
        for (int k = 0; k < 40; k++) begin
            #1;
            total++; if (clr_done_a !== 1'b0 || clr_busy_a !== 1'b0) begin bad++; $display("FAIL abort_no_done k=%0d got=%b%b want=00", k, clr_done_a, clr_busy_a); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            init     = ($urandom_range(0, 199) == 0);
            clr_req  = ($urandom_range(0, 39) == 0);
            we       = $urandom_range(0, 1);
            waddr    = 5'($urandom_range(0, 31));
            raddr1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2   = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            #1;
            total++; if (rdata1_a !== exp_a(raddr1) || rdata2_a !== exp_a(raddr2)) begin bad++; $display("FAIL rand_read_a n=%0d got=%h/%h want=%h/%h", n, rdata1_a, rdata2_a, exp_a(raddr1), exp_a(raddr2)); end
            total++; if (rdata1_b !== mb[raddr1] || rdata2_b !== mb[raddr2]) begin bad++; $display("FAIL rand_read_b n=%0d got=%h/%h want=%h/%h", n, rdata1_b, rdata2_b, mb[raddr1], mb[raddr2]); end
            total++; if (dbg_data_a !== ma[dbg_addr] || dbg_data_b !== mb[dbg_addr]) begin bad++; $display("FAIL rand_dbg n=%0d got=%h/%h want=%h/%h", n, dbg_data_a, dbg_data_b, ma[dbg_addr], mb[dbg_addr]); end
            total++; if ({wr_ready_a, clr_busy_a, clr_done_a} !== {clr_cyc < 0, clr_cyc >= 0 && clr_cyc < 32, clr_cyc == 32}) begin bad++; $display("FAIL rand_flags n=%0d got=%b cyc=%0d", n, {wr_ready_a, clr_busy_a, clr_done_a}, clr_cyc); end
            tick();
        end
        init = 1; we = 0; clr_req = 0;
        tick();
        init = 0;
    endtask

    task automatic test_small();
        s_we = 1; s_waddr = 7; s_wdata = 16'hABCD;
        tick();
        s_we = 0; s_raddr1 = 7; s_raddr2 = 6;
        #1;
        total++; if (s_rdata1 !== 16'hABCD || s_rdata2 !== 16'h0) begin bad++; $display("FAIL small_read got=%h/%h want=abcd/0000", s_rdata1, s_rdata2); end
        s_clr_req = 1;
        tick();
        s_clr_req = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if ({s_wr_ready, s_clr_busy, s_clr_done} !== 3'b010) begin bad++; $display("FAIL small_busy k=%0d got=%b want=010", k, {s_wr_ready, s_clr_busy, s_clr_done}); end
            tick();
        end
        #1;
        total++; if ({s_wr_ready, s_clr_busy, s_clr_done} !== 3'b001) begin bad++; $display("FAIL small_done got=%b want=001", {s_wr_ready, s_clr_busy, s_clr_done}); end
        tick();
        #1;
        total++; if ({s_wr_ready, s_clr_busy, s_clr_done} !== 3'b100) begin bad++; $display("FAIL small_idle got=%b want=100", {s_wr_ready, s_clr_busy, s_clr_done}); end
        total++; if (s_rdata1 !== 16'h0) begin bad++; $display("FAIL small_cleared got=%h want=0000", s_rdata1); end
    endtask

    initial begin
        init = 1; we = 0; clr_req = 0; waddr = 0; wdata = 0;
        raddr1 = 0; raddr2 = 0; dbg_addr = 0;
        s_we = 0; s_clr_req = 0; s_waddr = 0; s_wdata = 0;
        s_raddr1 = 0; s_raddr2 = 0; s_dbg_addr = 0;
        for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
